board_shuffler: RTL and testbench

- Parametrised successor to the fixed-permutation item-to-slot mapper. Places NUM_ITEMS input values into NUM_SLOTS board slots.
- Unused slots hold 0 (blank).
- In shuffle mode, an LFSR-driven Fisher-Yates shuffle gives a new arrangement on each start. In bypass mode, the layout is fixed identity.
- Sits between the game control FSM (start/done handshake) and the board display/compare logic.

---
 rtl/board_shuffler_pkg.sv | 30 +++
 rtl/board_shuffler_lfsr_gen.sv | 49 ++++
 rtl/board_shuffler.sv | 185 ++++++++++++++++++
 tb/tb_board_shuffler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_shuffler_pkg.sv
// Shared definitions for the board shuffler: FSM state encoding,
// default 16-bit LFSR constants and a ceil-log2 width helper.
package board_shuffler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_SHUFFLE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // x^16 + x^14 + x^13 + x^11 in right-shifting Galois form
   localparam logic [15:0] LFSR16_TAPS = 16'hB400;
   localparam logic [15:0] LFSR16_SEED = 16'hACE1;

   // Smallest w with 2**w >= n (n >= 2 in every use here)
   function automatic int clog2w(input int n);
      int w;
      w = 0;
      for (int b = 0; b < 31; b++) begin
         if ((32'sd1 <<< b) < n) begin
            w = b + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/board_shuffler_lfsr_gen.sv
// Galois LFSR with seed load. A zero seed is replaced by SEED so the
// register can never reach the all-zero lock-up state.
module lfsr_gen
   import board_shuffler_pkg::*;
#(
   parameter int           W    = 16,
   parameter logic [W-1:0] TAPS = W'(LFSR16_TAPS),
   parameter logic [W-1:0] SEED = W'(LFSR16_SEED)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] seed_in,
   output logic [W-1:0] lfsr
);

   logic [W-1:0] lfsr_r;
   logic [W-1:0] next_s;

   // Next value: seeded load (zero substituted) or one Galois step
   always_comb begin
      next_s = lfsr_r;
      if (load) begin
         if (seed_in == {W{1'b0}}) begin
            next_s = SEED;
         end else begin
            next_s = seed_in;
         end
      end else begin
         if (lfsr_r[0]) begin
            next_s = (lfsr_r >> 1) ^ TAPS;
         end else begin
            next_s = lfsr_r >> 1;
         end
      end
   end

   // LFSR state register, advances every clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= SEED;
      end else begin
         lfsr_r <= next_s;
      end
   end

   assign lfsr = lfsr_r;

endmodule

// File: rtl/board_shuffler.sv
// Places NUM_ITEMS values into NUM_SLOTS board slots, either in identity
// order or permuted by an LFSR-driven Fisher-Yates shuffle (one candidate
// index per cycle, out-of-range candidates rejected and retried).
module board_shuffler
   import board_shuffler_pkg::*;
#(
   parameter int                NUM_ITEMS = 15,
   parameter int                NUM_SLOTS = 36,
   parameter int                VAL_W     = 4,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       shuffle_en,
   input  logic                       seed_load,
   input  logic [LFSR_W-1:0]          seed_in,
   input  logic [NUM_ITEMS*VAL_W-1:0] items_in,
   output logic [NUM_SLOTS*VAL_W-1:0] slots_out,
   output logic                       busy,
   output logic                       done,
   output logic                       valid
);

   localparam int IDX_W = clog2w(NUM_SLOTS);

   state_t                    state_r, state_s;
   logic                      shuffle_r;
   logic                      busy_r, done_r, valid_r;
   logic                      busy_s, done_s, valid_s;
   logic [IDX_W-1:0]          i_r, mask_s, r_s;
   logic                      accept_s;
   logic                      seed_load_s;
   logic [LFSR_W-1:0]         lfsr_s;
   logic [NUM_SLOTS*VAL_W-1:0] load_vec_s;
   logic [VAL_W-1:0]          slot_r [NUM_SLOTS];
   logic                      unused_lfsr_hi_s;

   // Seeding is only honoured while idle so a running shuffle is never disturbed
   assign seed_load_s = seed_load & (state_r == ST_IDLE);

   lfsr_gen #(
      .W    (LFSR_W),
      .TAPS (LFSR_W'(LFSR16_TAPS)),
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst),
      .load    (seed_load_s),
      .seed_in (seed_in),
      .lfsr    (lfsr_s)
   );

   assign unused_lfsr_hi_s = ^lfsr_s[LFSR_W-1:IDX_W];

   // Items zero-extended to the full board; unused slots become blank
   assign load_vec_s = (NUM_SLOTS*VAL_W)'(items_in);

   // Candidate index: LFSR bits masked to the bit-length of i, accepted if <= i
   always_comb begin
      mask_s = i_r;
      for (int b = 1; b < IDX_W; b++) begin
         mask_s = mask_s | (i_r >> b);
      end
      r_s      = lfsr_s[IDX_W-1:0] & mask_s;
      accept_s = (state_r == ST_SHUFFLE) && (r_s <= i_r);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_LOAD;
            else       state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (shuffle_r) state_s = ST_SHUFFLE;
            else           state_s = ST_DONE;
         end
         ST_SHUFFLE: begin
            if (accept_s && (i_r == IDX_W'(1))) state_s = ST_DONE;
            else                                 state_s = ST_SHUFFLE;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM output logic, decoded from the next state so outputs can be registered
   always_comb begin
      busy_s  = 1'b0;
      done_s  = 1'b0;
      valid_s = valid_r;
      case (state_s)
         ST_IDLE: begin
            valid_s = valid_r;
         end
         ST_LOAD: begin
            busy_s  = 1'b1;
            valid_s = 1'b0;
         end
         ST_SHUFFLE: begin
            busy_s  = 1'b1;
         end
         ST_DONE: begin
            done_s  = 1'b1;
            valid_s = 1'b1;
         end
         default: begin
            busy_s  = 1'b0;
            done_s  = 1'b0;
            valid_s = 1'b0;
         end
      endcase
   end

   // Registered status outputs and shuffle-mode latch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         valid_r   <= 1'b0;
         shuffle_r <= 1'b0;
      end else begin
         busy_r  <= busy_s;
         done_r  <= done_s;
         valid_r <= valid_s;
         if ((state_r == ST_IDLE) && start) begin
            shuffle_r <= shuffle_en;
         end
      end
   end

   // Slot array: load items, then swap slot[i] with slot[r] on each accepted candidate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_r <= {IDX_W{1'b0}};
         for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_r[s] <= {VAL_W{1'b0}};
         end
      end else begin
         case (state_r)
            ST_LOAD: begin
               i_r <= IDX_W'(NUM_SLOTS - 1);
               for (int s = 0; s < NUM_SLOTS; s++) begin
                  slot_r[s] <= load_vec_s[s*VAL_W +: VAL_W];
               end
            end
            ST_SHUFFLE: begin
               if (accept_s) begin
                  slot_r[i_r] <= slot_r[r_s];
                  slot_r[r_s] <= slot_r[i_r];
                  i_r         <= i_r - IDX_W'(1);
               end
            end
            default: begin
               i_r <= i_r;
            end
         endcase
      end
   end

   genvar gs;
   generate
      for (gs = 0; gs < NUM_SLOTS; gs++) begin : g_out
         assign slots_out[gs*VAL_W +: VAL_W] = slot_r[gs];
      end
   endgenerate

   assign busy  = busy_r;
   assign done  = done_r;
   assign valid = valid_r;

endmodule

// File: tb/tb_board_shuffler.sv
// Self-checking bench for board_shuffler: a 15-item/36-slot instance and a
// 4-item/4-slot instance, both checked against a cycle-stepped reference
// model of the LFSR and the Fisher-Yates rejection-sampling shuffle.
module tb_board_shuffler;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] TAPS = 16'hB400;

   logic         clk;
   logic         rst;
   logic         start_v [2];
   logic         shuf_v  [2];
   logic         sl_v    [2];
   logic [15:0]  seed_v  [2];
   logic [59:0]  items_a;
   logic [15:0]  items_b;
   logic [143:0] slots_a;
   logic [15:0]  slots_b;
   logic         busy_v  [2];
   logic         done_v  [2];
   logic         valid_v [2];

   logic [15:0]  m_lfsr  [2];
   bit           m_busy  [2];
   logic [143:0] last_a;
   int           total;
   int           bad;

   board_shuffler dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .shuffle_en(shuf_v[0]),
      .seed_load(sl_v[0]), .seed_in(seed_v[0]), .items_in(items_a),
      .slots_out(slots_a), .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0])
   );

   board_shuffler #(.NUM_ITEMS(4), .NUM_SLOTS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .shuffle_en(shuf_v[1]),
      .seed_load(sl_v[1]), .seed_in(seed_v[1]), .items_in(items_b),
      .slots_out(slots_b), .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1])
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lstep(input logic [15:0] x);
      return {1'b0, x[15:1]} ^ (x[0] ? TAPS : 16'h0000);
   endfunction

   function automatic logic [15:0] dut_lfsr(input int d);
      return (d == 0) ? dut_a.lfsr_s : dut_b.lfsr_s;
   endfunction

   function automatic int item_of(input int d, input int s);
      return (d == 0) ? int'(items_a[s*4 +: 4]) : int'(items_b[s*4 +: 4]);
   endfunction

   // One clock edge; the reference LFSRs follow the same edge
   task automatic tick();
      logic [15:0] nx [2];
      for (int d = 0; d < 2; d++) begin
         if (!rst)                         nx[d] = SEED;
         else if (sl_v[d] && !m_busy[d])   nx[d] = (seed_v[d] == 16'h0000) ? SEED : seed_v[d];
         else                              nx[d] = lstep(m_lfsr[d]);
      end
      @(posedge clk);
      #1;
      m_lfsr[0] = nx[0];
      m_lfsr[1] = nx[1];
   endtask

   task automatic load_seed(input int d, input logic [15:0] s);
      sl_v[d] = 1'b1; seed_v[d] = s;
      tick();
      sl_v[d] = 1'b0;
   endtask

   // Full start..done..idle transaction checked cycle by cycle against the model
   task automatic do_run(input int d, input bit shuf, input bit disturb, input string tag);
      int ns, ni, i, k, r, tmp, cyc;
      int ms [36];
      logic [143:0] exp_v, act_v;
      ns = (d == 0) ? 36 : 4;
      ni = (d == 0) ? 15 : 4;
      for (int s = 0; s < 36; s++) ms[s] = 0;
      start_v[d] = 1'b1; shuf_v[d] = shuf;
      tick();
      start_v[d] = 1'b0; m_busy[d] = 1'b1;
      total++;
      if ({busy_v[d], done_v[d], valid_v[d]} !== 3'b100) begin
         bad++;
         $display("FAIL %s_accept: busy/done/valid=%b%b%b expected 100", tag, busy_v[d], done_v[d], valid_v[d]);
      end
      for (int s = 0; s < ni; s++) ms[s] = item_of(d, s);
      tick();
      if (shuf) begin
         i = ns - 1; cyc = 0;
         while (i >= 1 && cyc < 200) begin
            total++;
            if ({busy_v[d], done_v[d]} !== 2'b10) begin
               bad++;
               $display("FAIL %s_shuffling: busy/done=%b%b expected 10 at i=%0d", tag, busy_v[d], done_v[d], i);
            end
            k = 0;
            while (((1 << k) - 1) < i) k++;
            r = int'(m_lfsr[d]) % (1 << k);
            if (r <= i) begin
               tmp = ms[i]; ms[i] = ms[r]; ms[r] = tmp;
               i--;
            end
            if (disturb) begin
               start_v[d] = 1'($urandom_range(1, 0));
               sl_v[d]    = 1'($urandom_range(1, 0));
               seed_v[d]  = 16'($urandom);
            end
            tick();
            cyc++;
            start_v[d] = 1'b0; sl_v[d] = 1'b0;
         end
         if (i >= 1) begin
            total++; bad++;
            $display("FAIL %s_timeout: i=%0d still pending after %0d cycles, required 0", tag, i, cyc);
         end
      end
      total++;
      if ({busy_v[d], done_v[d], valid_v[d]} !== 3'b011) begin
         bad++;
         $display("FAIL %s_done: busy/done/valid=%b%b%b expected 011", tag, busy_v[d], done_v[d], valid_v[d]);
      end
      exp_v = '0;
      for (int s = 0; s < ns; s++) exp_v[s*4 +: 4] = 4'(ms[s]);
      act_v = (d == 0) ? slots_a : {128'h0, slots_b};
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s_slots: got %h expected %h", tag, act_v, exp_v);
      end
      total++;
      if (dut_lfsr(d) !== m_lfsr[d]) begin
         bad++;
         $display("FAIL %s_lfsr: got %h expected %h", tag, dut_lfsr(d), m_lfsr[d]);
      end
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0; m_busy[d] = 1'b0;
      total++;
      if ({busy_v[d], done_v[d], valid_v[d]} !== 3'b001) begin
         bad++;
         $display("FAIL %s_after_done: busy/done/valid=%b%b%b expected 001", tag, busy_v[d], done_v[d], valid_v[d]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      total++;
      if (slots_a !== 144'h0 || slots_b !== 16'h0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: slots=%h busy/done/valid=%b%b%b expected all 0", slots_a, busy_v[0], done_v[0], valid_v[0]);
      end
      rst = 1'b1;
      total++;
      if (dut_lfsr(0) !== 16'hACE1 || dut_lfsr(1) !== 16'hACE1) begin
         bad++;
         $display("FAIL reset_lfsr: got %h/%h expected ace1", dut_lfsr(0), dut_lfsr(1));
      end
   endtask

   task automatic test_bypass();
      for (int k = 0; k < 15; k++) items_a[k*4 +: 4] = 4'(k + 1);
      do_run(0, 1'b0, 1'b0, "bypass");
      total++;
      if (slots_a[59:0] !== 60'hFEDCBA987654321 || slots_a[143:60] !== 84'h0) begin
         bad++;
         $display("FAIL bypass_identity: got %h expected identity 1..15 then zeros", slots_a);
      end
   endtask

   task automatic test_seed_zero();
      load_seed(0, 16'h0000);
      total++;
      if (dut_lfsr(0) !== 16'hACE1) begin
         bad++;
         $display("FAIL seed_zero: got %h expected ace1", dut_lfsr(0));
      end
   endtask

   task automatic test_shuffle();
      int cnt [16];
      for (int k = 0; k < 15; k++) items_a[k*4 +: 4] = 4'(k + 1);
      load_seed(0, 16'h1234);
      total++;
      if (dut_lfsr(0) !== 16'h1234) begin
         bad++;
         $display("FAIL seed_load: got %h expected 1234", dut_lfsr(0));
      end
      tick();
      do_run(0, 1'b1, 1'b0, "shuffle1234");
      for (int v = 0; v < 16; v++) cnt[v] = 0;
      for (int s = 0; s < 36; s++) cnt[slots_a[s*4 +: 4]]++;
      total++;
      if (cnt[0] != 21 || cnt[1] != 1 || cnt[7] != 1 || cnt[15] != 1 ||
          cnt[2] + cnt[3] + cnt[4] + cnt[5] + cnt[6] + cnt[8] + cnt[9] + cnt[10] +
          cnt[11] + cnt[12] + cnt[13] + cnt[14] != 12) begin
         bad++;
         $display("FAIL multiset: zeros=%0d got layout %h expected 21 zeros and 1..15 once", cnt[0], slots_a);
      end
      for (int v = 1; v < 16; v++) begin
         if (cnt[v] != 1) begin
            total++; bad++;
            $display("FAIL multiset_value: value %0d appears %0d times expected 1", v, cnt[v]);
         end
      end
      last_a = slots_a;
      load_seed(0, 16'h1234);
      tick();
      do_run(0, 1'b1, 1'b0, "repeat1234");
      total++;
      if (slots_a !== last_a) begin
         bad++;
         $display("FAIL repeat_layout: got %h expected %h", slots_a, last_a);
      end
   endtask

   task automatic test_busy_disturb();
      load_seed(0, 16'($urandom));
      do_run(0, 1'b1, 1'b1, "disturb");
   endtask

   task automatic test_random();
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 15; k++) items_a[k*4 +: 4] = 4'($urandom_range(15, 0));
         load_seed(0, 16'($urandom));
         for (int w = $urandom_range(4, 0); w > 0; w--) tick();
         do_run(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "random");
      end
   endtask

   task automatic test_small();
      items_b = 16'h4321;
      do_run(1, 1'b0, 1'b0, "small_bypass");
      total++;
      if (slots_b !== 16'h4321) begin
         bad++;
         $display("FAIL small_identity: got %h expected 4321", slots_b);
      end
      for (int n = 0; n < 4; n++) begin
         items_b = 16'($urandom);
         load_seed(1, 16'($urandom));
         do_run(1, 1'b1, 1'b0, "small_shuffle");
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 15; k++) items_a[k*4 +: 4] = 4'(k + 1);
      start_v[0] = 1'b1; shuf_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0; m_busy[0] = 1'b1;
      tick(); tick(); tick();
      #2;
      rst = 1'b0;
      #1;
      m_lfsr[0] = SEED; m_lfsr[1] = SEED;
      m_busy[0] = 1'b0; m_busy[1] = 1'b0;
      total++;
      if (slots_a !== 144'h0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || valid_v[0] !== 1'b0 ||
          dut_lfsr(0) !== 16'hACE1) begin
         bad++;
         $display("FAIL reset_mid: slots=%h busy/done/valid=%b%b%b lfsr=%h expected zeros and ace1",
                  slots_a, busy_v[0], done_v[0], valid_v[0], dut_lfsr(0));
      end
      tick();
      rst = 1'b1;
      do_run(0, 1'b1, 1'b0, "after_reset");
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      total = 0; bad = 0;
      items_a = 60'h0; items_b = 16'h0;
      for (int d = 0; d < 2; d++) begin
         start_v[d] = 1'b0; shuf_v[d] = 1'b0; sl_v[d] = 1'b0; seed_v[d] = 16'h0000;
         m_lfsr[d] = SEED; m_busy[d] = 1'b0;
      end
      test_reset();
      test_bypass();
      test_seed_zero();
      test_shuffle();
      test_busy_disturb();
      test_random();
      test_small();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
